// File: rtl/iot_event_arbiter.sv
// rtl/iot_event_arbiter.sv - round-robin serialiser of device status changes into change/on_off pulses
// Optional IOT_SYNC_EN: 2-flop input synchroniser in front of the arbiter.
module iot_event_arbiter #(
  parameter int N_DEV = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_DEV-1:0] dev_status,
  output logic             change,
  output logic             on_off,
  output logic [N_DEV-1:0] reported,
  output logic             pending
);
  localparam int PW = $clog2(N_DEV);

  logic [N_DEV-1:0] status_d, status_q;
  logic [N_DEV-1:0] reported_d, reported_q;
  logic [PW-1:0]    rr_ptr_d, rr_ptr_q;
  logic             change_d, change_q;
  logic             on_off_d, on_off_q;

  logic [N_DEV-1:0] pend_vec;
  logic             grant_valid;
  logic [PW-1:0]    grant_idx;
  logic             hi_found;
  logic [PW-1:0]    hi_idx;
  logic [PW-1:0]    lo_idx;

`ifdef IOT_SYNC_EN
  logic [N_DEV-1:0] meta_d, meta_q;

  always_comb begin
    meta_d   = dev_status;
    status_d = meta_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) meta_q <= '0;
    else     meta_q <= meta_d;
  end
`else
  always_comb begin
    status_d = dev_status;
  end
`endif

  assign pend_vec = status_q ^ reported_q;

  // Lowest pending index at or above the pointer wins; otherwise wrap to the lowest overall.
  always_comb begin
    grant_valid = 1'b0;
    hi_found    = 1'b0;
    hi_idx      = '0;
    lo_idx      = '0;
    for (int i = N_DEV - 1; i >= 0; i--) begin
      if (pend_vec[i]) begin
        grant_valid = 1'b1;
        lo_idx      = PW'(i);
        if (i >= int'(rr_ptr_q)) begin
          hi_found = 1'b1;
          hi_idx   = PW'(i);
        end
      end
    end
    grant_idx = hi_found ? hi_idx : lo_idx;
  end

  always_comb begin
    reported_d = reported_q;
    rr_ptr_d   = rr_ptr_q;
    change_d   = 1'b0;
    on_off_d   = 1'b0;
    if (grant_valid) begin
      change_d              = 1'b1;
      on_off_d              = status_q[grant_idx];
      reported_d[grant_idx] = status_q[grant_idx];
      if (int'(grant_idx) == N_DEV - 1) rr_ptr_d = '0;
      else                              rr_ptr_d = grant_idx + PW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      status_q   <= '0;
      reported_q <= '0;
      rr_ptr_q   <= '0;
      change_q   <= 1'b0;
      on_off_q   <= 1'b0;
    end else begin
      status_q   <= status_d;
      reported_q <= reported_d;
      rr_ptr_q   <= rr_ptr_d;
      change_q   <= change_d;
      on_off_q   <= on_off_d;
    end
  end

  assign change   = change_q;
  assign on_off   = on_off_q;
  assign reported = reported_q;
  assign pending  = |pend_vec;

endmodule
